bridge_split_odd: RTL
=====================

// Module: bridge_split_odd
// PURPOSE
//   Width down-converter: accepts wide words of DIN_W elements and emits a continuous
//   stream of DOUT_W-element beats. DIN_W need not be a multiple of DOUT_W, so output
//   beats straddle input-word boundaries. Packet boundaries are carried by last_i/last_o.
//   Mirror of bridge_combine_odd; sits on the consumer side of a wide bus to feed
//   narrow-lane compute.
// PARAMETERS
//   DIN_W   32  elements per input word
//   DOUT_W  3   elements per output beat (1 <= DOUT_W <= DIN_W)
//   DATA_W  8   bits per element
// PORTS
//   clk      in   1                   clock, all logic on rising edge
//   a_rst_n  in   1                   asynchronous active-low reset
//   vld_i    in   1                   input word valid
//   din      in   [DIN_W][DATA_W]     input word, element 0 = first in stream order
//   cnt_i    in   $clog2(DIN_W+1)     valid elements in din (low indices); used only when last_i=1, else DIN_W implied
//   last_i   in   1                   final word of packet
//   rdy_o    out  1                   block can accept a word
//   vld_o    out  1                   output beat valid
//   dout     out  [DOUT_W][DATA_W]    output beat, element 0 = first
//   cnt_o    out  $clog2(DOUT_W+1)    valid elements in dout (low indices)
//   last_o   out  1                   final beat of packet
//   rdy_i    in   1                   downstream ready
// BEHAVIOUR
// - Reset: asynchronous, active-low; clk is the only clock. occ_q=0, state=FILL,
//   buffer cleared. Outputs while reset is held and after it is released: rdy_o=1,
//   vld_o=0, dout=0, cnt_o=0, last_o=0.
// - Buffer: BUF_N = DIN_W+DOUT_W-1 elements, shift-style. Head at index 0.
//   occ_q counts valid elements.
// - Handshake: a transfer happens on a clock edge with vld&rdy high. Once vld_o rises,
//   vld_o, dout, cnt_o and last_o are held stable until rdy_i. rdy_o does not depend on vld_i.
// - States:
//   FILL  : occ_q<DOUT_W and no last pending. rdy_o=1, vld_o=0.
//           Accepted word is appended at index occ_q. occ_q += DIN_W, or += cnt_i on last.
//           Last accepted -> FLUSH. Else occ_q>=DOUT_W -> DRAIN, else stay in FILL.
//   DRAIN : occ_q>=DOUT_W. vld_o=1, dout=buf[0..DOUT_W-1], cnt_o=DOUT_W, last_o=0, rdy_o=0.
//           On a transfer: shift by DOUT_W, occ_q -= DOUT_W.
//           Then occ_q<DOUT_W -> FILL.
//   FLUSH : last received; rdy_o=0, vld_o=1.
//           occ_q>DOUT_W: full beat, last_o=0.
//           occ_q<=DOUT_W: cnt_o=occ_q, unused lanes of dout=0, last_o=1.
//           A transfer with last_o=1 sets occ_q=0 -> FILL.
// - rdy_o and vld_o are never high together: no simultaneous accept/emit.
//   This guarantees occ_q+DIN_W <= BUF_N.
// - Latency: word accepted at edge N -> first beat valid in the cycle after N.
//   Throughput: ceil-style, one bubble per input word.
// - Zero-length tail: last_i with cnt_i=0 and occ_q=0 -> one beat with cnt_o=0,
//   last_o=1, dout=0.
// - last_i with cnt_i>DIN_W is illegal; the bench asserts on it.
// - No elements are carried across packets. A new packet always starts at dout[0].
// - Reset asserted mid-packet: all state is dropped immediately.
//   The next packet starts clean after reset is released.
// TESTING (DIN_W=32, DOUT_W=3, DATA_W=8; data = element index)
// 1 One word 0..31, last_i=1, cnt_i=32, rdy_i=1 -> 11 beats:
//   (0,1,2)..(27,28,29), then (30,31,0) with cnt_o=2, last_o=1.
// 2 Two words 0..31, 32..63 (second last, cnt_i=32) -> beat 10=(30,31,32) straddles;
//   21 full beats, beat 21=(63,0,0) with cnt_o=1, last_o=1.
// 3 Case 2 with rdy_i pattern 4 cycles high / 12 cycles low -> identical beat sequence;
//   dout/cnt_o/last_o stable while vld_o&!rdy_i; no loss or duplication.
// 4 Word 0..31 then last word cnt_i=1 (element 32) -> 11 full beats;
//   beat 10=(30,31,32) with cnt_o=3, last_o=1.
// 5 Pull a_rst_n low during DRAIN of case 1 -> vld_o=0 immediately (async reset).
//   After release: rdy_o=1; a fresh case 1 reproduces its exact sequence.
// 6 last_i with cnt_i=0 into an empty buffer -> single beat: vld_o=1, cnt_o=0,
//   last_o=1, dout=0.

Source files
------------

// File: rtl/bridge_split_odd.sv
// Width down-converter: wide input words are split into a continuous stream of narrow beats,
// with output beats allowed to straddle input-word boundaries. Packet ends travel on last.
module bridge_split_odd #(
    parameter int unsigned DIN_W  = 32,
    parameter int unsigned DOUT_W = 3,
    parameter int unsigned DATA_W = 8
) (
    input  logic                               clk,
    input  logic                               a_rst_n,
    input  logic                               vld_i,
    input  logic [DIN_W-1:0][DATA_W-1:0]       din,
    input  logic [$clog2(DIN_W+1)-1:0]         cnt_i,
    input  logic                               last_i,
    output logic                               rdy_o,
    output logic                               vld_o,
    output logic [DOUT_W-1:0][DATA_W-1:0]      dout,
    output logic [$clog2(DOUT_W+1)-1:0]        cnt_o,
    output logic                               last_o,
    input  logic                               rdy_i
);

    localparam int unsigned BUF_N = DIN_W + DOUT_W - 1;
    localparam int unsigned OCC_W = $clog2(BUF_N + 1);
    localparam int unsigned CNT_W = $clog2(DOUT_W + 1);

    typedef enum logic [1:0] {StFill, StDrain, StFlush} state_e;

    state_e                         state_q, state_d;
    logic [BUF_N-1:0][DATA_W-1:0]   buf_q, buf_d;
    logic [OCC_W-1:0]               occ_q, occ_d;

    int unsigned                    n_in;
    int unsigned                    occ_n;
    logic [DIN_W-1:0][DATA_W-1:0]   din_m;
    logic [BUF_N-1:0][DATA_W-1:0]   app;
    logic                           full_beat;

    // Elements past the valid count are zeroed so the buffer tail above occ_q stays clear
    // and appends can simply be OR-ed in.
    always_comb begin
        n_in = last_i ? 32'(cnt_i) : DIN_W;
        for (int unsigned i = 0; i < DIN_W; i++) begin
            din_m[i] = (i < n_in) ? din[i] : '0;
        end
        app = '0;
        app[DIN_W-1:0] = din_m;
        occ_n = 32'(occ_q) + n_in;
    end

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        occ_d   = occ_q;
        unique case (state_q)
            StFill: begin
                if (vld_i) begin
                    buf_d = buf_q | (app << (32'(occ_q) * DATA_W));
                    occ_d = OCC_W'(occ_n);
                    if (last_i) begin
                        state_d = StFlush;
                    end else if (occ_n >= DOUT_W) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (rdy_i) begin
                    buf_d = buf_q >> (DOUT_W * DATA_W);
                    occ_d = occ_q - OCC_W'(DOUT_W);
                    if (32'(occ_q) - DOUT_W < DOUT_W) begin
                        state_d = StFill;
                    end
                end
            end
            StFlush: begin
                if (rdy_i) begin
                    if (32'(occ_q) > DOUT_W) begin
                        buf_d = buf_q >> (DOUT_W * DATA_W);
                        occ_d = occ_q - OCC_W'(DOUT_W);
                    end else begin
                        // Packet done: nothing carries over into the next one.
                        buf_d   = '0;
                        occ_d   = '0;
                        state_d = StFill;
                    end
                end
            end
            default: state_d = StFill;
        endcase
    end

    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            state_q <= StFill;
            buf_q   <= '0;
            occ_q   <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            occ_q   <= occ_d;
        end
    end

    // Outputs decode straight from state registers, so they hold while the sink stalls.
    always_comb begin
        rdy_o     = (state_q == StFill);
        vld_o     = (state_q == StDrain) || (state_q == StFlush);
        full_beat = (state_q == StDrain) || ((state_q == StFlush) && (32'(occ_q) > DOUT_W));
        for (int unsigned i = 0; i < DOUT_W; i++) begin
            dout[i] = (vld_o && (i < 32'(occ_q))) ? buf_q[i] : '0;
        end
        if (full_beat) begin
            cnt_o = CNT_W'(DOUT_W);
        end else if (state_q == StFlush) begin
            cnt_o = CNT_W'(occ_q);
        end else begin
            cnt_o = '0;
        end
        last_o = (state_q == StFlush) && !full_beat;
    end

endmodule
